preg_ready_table: RTL and testbench



---
 rtl/preg_ready_table.sv | 188 ++++++++++++++++++
 tb/tb_preg_ready_table.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/preg_ready_table.sv
// -----------------------------------------------------------------------------
// preg_ready_table
//   Physical-register ready (busy) table answering the issue stage's ready
//   lookup. Rename clears a bit when it allocates a pdst; execute wakeups and
//   retire set it again; flush returns the whole table to all-ready.
//   Lookups are combinational and bypass same-cycle wakeups/retires, so a
//   consumer renamed in the cycle its producer wakes is already seen ready.
//   An older slot of the same rename group allocating the looked-up preg
//   forces not-ready. Preg 0 is hard-wired ready.
//
// Ports
//   clk, reset      clock; asynchronous active-high reset (table -> all ready)
//   flush           squash: table -> all ready, same-cycle updates ignored
//   alloc_valid/preg   per-slot destination allocation (clears ready)
//   psrc1/psrc2     per-slot lookup addresses
//   v1/v2           per-slot source ready (combinational)
//   wake_valid/preg    execute wakeup ports (set ready)
//   retire_valid/preg  retire ports (set ready)
//
// Optional build macro PRT_PERF_EN adds:
//   busy_cnt        registered count of busy pregs, one cycle behind the table
//   alloc_conflict  registered pulse: alloc and wake/retire hit the same preg
// -----------------------------------------------------------------------------
module preg_ready_table #(
  parameter int PREG_NUM     = 64,
  parameter int FETCH_WIDTH  = 4,
  parameter int WAKE_WIDTH   = 4,
  parameter int COMMIT_WIDTH = 4,
  localparam int PREG_W      = $clog2(PREG_NUM)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [FETCH_WIDTH-1:0]         alloc_valid,
  input  logic [FETCH_WIDTH*PREG_W-1:0]  alloc_preg,
  input  logic [FETCH_WIDTH*PREG_W-1:0]  psrc1,
  input  logic [FETCH_WIDTH*PREG_W-1:0]  psrc2,
  output logic [FETCH_WIDTH-1:0]         v1,
  output logic [FETCH_WIDTH-1:0]         v2,
  input  logic [WAKE_WIDTH-1:0]          wake_valid,
  input  logic [WAKE_WIDTH*PREG_W-1:0]   wake_preg,
  input  logic [COMMIT_WIDTH-1:0]        retire_valid,
  input  logic [COMMIT_WIDTH*PREG_W-1:0] retire_preg
`ifdef PRT_PERF_EN
  ,
  output logic [PREG_W:0]                busy_cnt,
  output logic                           alloc_conflict
`endif
);

  logic [PREG_NUM-1:0]    rdy_q;
  logic [PREG_NUM-1:0]    rdy_d;
  logic [PREG_NUM-1:0]    set_vec_s;
  logic [PREG_NUM-1:0]    clr_vec_s;
  logic [FETCH_WIDTH-1:0] intra1_s;
  logic [FETCH_WIDTH-1:0] intra2_s;

  // Decode wake and retire ports into a one-hot-OR set vector.
  always_comb begin
    set_vec_s = {PREG_NUM{1'b0}};
    for (int k = 0; k < WAKE_WIDTH; k++) begin
      if (wake_valid[k]) begin
        set_vec_s[wake_preg[k*PREG_W +: PREG_W]] = 1'b1;
      end else begin
        set_vec_s = set_vec_s;
      end
    end
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (retire_valid[k]) begin
        set_vec_s[retire_preg[k*PREG_W +: PREG_W]] = 1'b1;
      end else begin
        set_vec_s = set_vec_s;
      end
    end
  end

  // Decode allocations into a clear vector; preg 0 is never cleared.
  always_comb begin
    clr_vec_s = {PREG_NUM{1'b0}};
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (alloc_valid[i] && (alloc_preg[i*PREG_W +: PREG_W] != {PREG_W{1'b0}})) begin
        clr_vec_s[alloc_preg[i*PREG_W +: PREG_W]] = 1'b1;
      end else begin
        clr_vec_s = clr_vec_s;
      end
    end
  end

  // Next table state: flush wins, then clear (new lifetime) beats set.
  always_comb begin
    if (flush) begin
      rdy_d = {PREG_NUM{1'b1}};
    end else begin
      rdy_d = (rdy_q | set_vec_s) & ~clr_vec_s;
    end
    rdy_d[0] = 1'b1;
  end

  // Ready table register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q <= {PREG_NUM{1'b1}};
    end else begin
      rdy_q <= rdy_d;
    end
  end

  // Same-group hazard: only strictly older slots' allocations count.
  always_comb begin
    intra1_s = {FETCH_WIDTH{1'b0}};
    intra2_s = {FETCH_WIDTH{1'b0}};
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      for (int j = 0; j < i; j++) begin
        if (alloc_valid[j] && (alloc_preg[j*PREG_W +: PREG_W] == psrc1[i*PREG_W +: PREG_W])) begin
          intra1_s[i] = 1'b1;
        end else begin
          intra1_s[i] = intra1_s[i];
        end
        if (alloc_valid[j] && (alloc_preg[j*PREG_W +: PREG_W] == psrc2[i*PREG_W +: PREG_W])) begin
          intra2_s[i] = 1'b1;
        end else begin
          intra2_s[i] = intra2_s[i];
        end
      end
    end
  end

  // Lookup: table bit OR same-cycle wake/retire bypass, masked by hazard.
  always_comb begin
    v1 = {FETCH_WIDTH{1'b0}};
    v2 = {FETCH_WIDTH{1'b0}};
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (psrc1[i*PREG_W +: PREG_W] == {PREG_W{1'b0}}) begin
        v1[i] = 1'b1;
      end else begin
        v1[i] = (rdy_q[psrc1[i*PREG_W +: PREG_W]] | set_vec_s[psrc1[i*PREG_W +: PREG_W]])
                & ~intra1_s[i];
      end
      if (psrc2[i*PREG_W +: PREG_W] == {PREG_W{1'b0}}) begin
        v2[i] = 1'b1;
      end else begin
        v2[i] = (rdy_q[psrc2[i*PREG_W +: PREG_W]] | set_vec_s[psrc2[i*PREG_W +: PREG_W]])
                & ~intra2_s[i];
      end
    end
  end

`ifdef PRT_PERF_EN
  logic [PREG_W:0] busy_cnt_q;
  logic [PREG_W:0] busy_cnt_d;
  logic            alloc_conflict_q;
  logic            alloc_conflict_d;

  function automatic logic [PREG_W:0] count_ones(input logic [PREG_NUM-1:0] vec);
    logic [PREG_W:0] cnt;
    cnt = {(PREG_W+1){1'b0}};
    for (int k = 0; k < PREG_NUM; k++) begin
      cnt = cnt + {{PREG_W{1'b0}}, vec[k]};
    end
    return cnt;
  endfunction

  // Perf next values: busy count of the current table, alloc/set collision.
  always_comb begin
    busy_cnt_d = count_ones(~rdy_q);
    if (flush) begin
      alloc_conflict_d = 1'b0;
    end else begin
      alloc_conflict_d = |(clr_vec_s & set_vec_s);
    end
  end

  // Perf registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt_q       <= {(PREG_W+1){1'b0}};
      alloc_conflict_q <= 1'b0;
    end else begin
      busy_cnt_q       <= busy_cnt_d;
      alloc_conflict_q <= alloc_conflict_d;
    end
  end

  assign busy_cnt       = busy_cnt_q;
  assign alloc_conflict = alloc_conflict_q;
`endif

endmodule

// File: tb/tb_preg_ready_table.sv
// -----------------------------------------------------------------------------
// tb_preg_ready_table
//   Directed scenarios plus randomized traffic for preg_ready_table, checked
//   against a behavioural model: a 64-entry ready array updated from the
//   table rules, with lookups evaluated directly from the lookup formula.
// -----------------------------------------------------------------------------
module tb_preg_ready_table;

  localparam int W = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [3:0]  alloc_valid;
  logic [23:0] alloc_preg;
  logic [23:0] psrc1;
  logic [23:0] psrc2;
  logic [3:0]  v1;
  logic [3:0]  v2;
  logic [3:0]  wake_valid;
  logic [23:0] wake_preg;
  logic [3:0]  retire_valid;
  logic [23:0] retire_preg;
`ifdef PRT_PERF_EN
  logic [6:0]  busy_cnt;
  logic        alloc_conflict;
  int          m_busy;
  bit          m_conf;
`endif

  int checks = 0;
  int errors = 0;
  bit m_rdy [64];

  preg_ready_table dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .alloc_valid  (alloc_valid),
    .alloc_preg   (alloc_preg),
    .psrc1        (psrc1),
    .psrc2        (psrc2),
    .v1           (v1),
    .v2           (v2),
    .wake_valid   (wake_valid),
    .wake_preg    (wake_preg),
    .retire_valid (retire_valid),
    .retire_preg  (retire_preg)
`ifdef PRT_PERF_EN
    ,
    .busy_cnt       (busy_cnt),
    .alloc_conflict (alloc_conflict)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  // Expected ready bits for the four lookups in ps, from the current model.
  function automatic logic [3:0] exp_v(input logic [23:0] ps);
    logic [3:0] r;
    int p;
    bit hit;
    bit intra;
    for (int i = 0; i < 4; i++) begin
      p = int'(ps[i*W +: W]);
      hit = m_rdy[p];
      for (int k = 0; k < 4; k++) begin
        if (wake_valid[k] && int'(wake_preg[k*W +: W]) == p) hit = 1'b1;
        if (retire_valid[k] && int'(retire_preg[k*W +: W]) == p) hit = 1'b1;
      end
      intra = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (alloc_valid[j] && int'(alloc_preg[j*W +: W]) == p) intra = 1'b1;
      end
      r[i] = (p == 0) ? 1'b1 : (hit && !intra);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 64; p++) m_rdy[p] = 1'b1;
`ifdef PRT_PERF_EN
    m_busy = 0;
    m_conf = 1'b0;
`endif
  endtask

  task automatic clear_inputs();
    flush = 1'b0;
    alloc_valid = 4'd0;  alloc_preg = 24'd0;
    wake_valid = 4'd0;   wake_preg = 24'd0;
    retire_valid = 4'd0; retire_preg = 24'd0;
    psrc1 = 24'd0;       psrc2 = 24'd0;
  endtask

  // Advance one clock edge and apply the table rules to the model.
  task automatic tick();
    bit set_v [64];
    bit clr_v [64];
    int busy;
    bit conf;
    @(posedge clk);
    for (int p = 0; p < 64; p++) begin set_v[p] = 1'b0; clr_v[p] = 1'b0; end
    for (int k = 0; k < 4; k++) begin
      if (wake_valid[k]) set_v[int'(wake_preg[k*W +: W])] = 1'b1;
      if (retire_valid[k]) set_v[int'(retire_preg[k*W +: W])] = 1'b1;
      if (alloc_valid[k] && alloc_preg[k*W +: W] != 6'd0) clr_v[int'(alloc_preg[k*W +: W])] = 1'b1;
    end
    busy = 0;
    conf = 1'b0;
    for (int p = 0; p < 64; p++) begin
      if (!m_rdy[p]) busy++;
      if (set_v[p] && clr_v[p] && !flush) conf = 1'b1;
    end
`ifdef PRT_PERF_EN
    m_busy = busy;
    m_conf = conf;
`endif
    for (int p = 0; p < 64; p++) begin
      if (flush) m_rdy[p] = 1'b1;
      else if (clr_v[p]) m_rdy[p] = 1'b0;
      else if (set_v[p]) m_rdy[p] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    psrc1 = pack4(3, 7, 0, 63);
    #2;
    checks++;
    if (v1 !== 4'b1111) begin
      errors++; $display("FAIL reset_v1: got %b expected %b", v1, 4'b1111);
    end
    checks++;
    if (v2 !== 4'b1111) begin
      errors++; $display("FAIL reset_v2: got %b expected %b", v2, 4'b1111);
    end
`ifdef PRT_PERF_EN
    checks++;
    if (busy_cnt !== 7'd0) begin
      errors++; $display("FAIL reset_busy_cnt: got %0d expected 0", busy_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_alloc_wake_bypass();
    clear_inputs();
    alloc_valid = 4'b0001; alloc_preg = pack4(5, 0, 0, 0);
    tick();
    clear_inputs();
    psrc1 = pack4(0, 0, 5, 0);
    #2;
    checks++;
    if (v1[2] !== 1'b0) begin
      errors++; $display("FAIL alloc_busy: v1[2] got %b expected 0", v1[2]);
    end
    wake_valid = 4'b0001; wake_preg = pack4(5, 0, 0, 0);
    #1;
    checks++;
    if (v1[2] !== 1'b1) begin
      errors++; $display("FAIL wake_bypass: v1[2] got %b expected 1", v1[2]);
    end
    tick();
    wake_valid = 4'd0;
    #2;
    checks++;
    if (v1[2] !== 1'b1) begin
      errors++; $display("FAIL wake_table: v1[2] got %b expected 1", v1[2]);
    end
    tick();
  endtask

  task automatic test_intra_group();
    clear_inputs();
    psrc2 = pack4(9, 0, 9, 0);
    alloc_valid = 4'b1000; alloc_preg = pack4(0, 0, 0, 9);
    #2;
    checks++;
    if (v2[2] !== 1'b1) begin
      errors++; $display("FAIL younger_alloc: v2[2] got %b expected 1", v2[2]);
    end
    alloc_valid = 4'b1001; alloc_preg = pack4(9, 0, 0, 9);
    #2;
    checks++;
    if (v2[2] !== 1'b0) begin
      errors++; $display("FAIL older_alloc: v2[2] got %b expected 0", v2[2]);
    end
    checks++;
    if (v2[0] !== 1'b1) begin
      errors++; $display("FAIL self_slot: v2[0] got %b expected 1", v2[0]);
    end
    alloc_valid = 4'd0;
    tick();
  endtask

  task automatic test_alloc_wake_conflict();
    clear_inputs();
    alloc_valid = 4'b0001; alloc_preg = pack4(12, 0, 0, 0);
    wake_valid = 4'b0001;  wake_preg = pack4(12, 0, 0, 0);
    tick();
    clear_inputs();
    psrc1 = pack4(12, 0, 0, 0);
    #1;
`ifdef PRT_PERF_EN
    checks++;
    if (alloc_conflict !== 1'b1) begin
      errors++; $display("FAIL conflict_pulse: got %b expected 1", alloc_conflict);
    end
`endif
    #1;
    checks++;
    if (v1[0] !== 1'b0) begin
      errors++; $display("FAIL alloc_beats_wake: v1[0] got %b expected 0", v1[0]);
    end
    tick();
`ifdef PRT_PERF_EN
    checks++;
    if (alloc_conflict !== 1'b0) begin
      errors++; $display("FAIL conflict_clear: got %b expected 0", alloc_conflict);
    end
`endif
  endtask

  task automatic test_flush();
    clear_inputs();
    wake_valid = 4'b0001; wake_preg = pack4(12, 0, 0, 0);
    tick();
    clear_inputs();
    alloc_valid = 4'b1111; alloc_preg = pack4(10, 11, 12, 13);
    tick();
    clear_inputs();
    tick();
    psrc1 = pack4(10, 11, 12, 13);
    #2;
    checks++;
    if (v1 !== 4'b0000) begin
      errors++; $display("FAIL pre_flush_busy: v1 got %b expected 0000", v1);
    end
`ifdef PRT_PERF_EN
    checks++;
    if (busy_cnt !== 7'd4) begin
      errors++; $display("FAIL busy_cnt_pre_flush: got %0d expected 4", busy_cnt);
    end
`endif
    flush = 1'b1;
    alloc_valid = 4'b0011; alloc_preg = pack4(20, 21, 0, 0);
    wake_valid = 4'b0001;  wake_preg = pack4(10, 0, 0, 0);
    tick();
    clear_inputs();
    tick();
`ifdef PRT_PERF_EN
    checks++;
    if (busy_cnt !== 7'd0) begin
      errors++; $display("FAIL busy_cnt_post_flush: got %0d expected 0", busy_cnt);
    end
`endif
    for (int g = 0; g < 16; g++) begin
      psrc1 = pack4(4*g, 4*g+1, 4*g+2, 4*g+3);
      psrc2 = pack4(4*g+3, 4*g+2, 4*g+1, 4*g);
      #2;
      checks++;
      if ({v1, v2} !== 8'hFF) begin
        errors++; $display("FAIL flush_all_ready: group %0d v1 %b v2 %b expected 1111 1111", g, v1, v2);
      end
      tick();
    end
  endtask

  task automatic test_preg0();
    clear_inputs();
    alloc_valid = 4'b0010; alloc_preg = pack4(0, 0, 0, 0);
    psrc1 = pack4(0, 0, 0, 0);
    #2;
    checks++;
    if (v1 !== 4'b1111) begin
      errors++; $display("FAIL preg0_same_cycle: v1 got %b expected 1111", v1);
    end
    tick();
    alloc_valid = 4'd0;
    #2;
    checks++;
    if (v1 !== 4'b1111) begin
      errors++; $display("FAIL preg0_table: v1 got %b expected 1111", v1);
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] e1;
    logic [3:0] e2;
    for (int c = 0; c < 500; c++) begin
      flush = ($urandom_range(0, 39) == 0);
      alloc_valid  = 4'($urandom) & 4'($urandom);
      wake_valid   = 4'($urandom) & 4'($urandom);
      retire_valid = 4'($urandom) & 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        alloc_preg[i*W +: W]  = 6'($urandom_range(0, ($urandom_range(0, 1) == 0) ? 15 : 63));
        wake_preg[i*W +: W]   = 6'($urandom_range(0, 15));
        retire_preg[i*W +: W] = 6'($urandom_range(0, 63));
        psrc1[i*W +: W]       = 6'($urandom_range(0, 15));
        psrc2[i*W +: W]       = 6'($urandom_range(0, ($urandom_range(0, 1) == 0) ? 15 : 63));
      end
      #2;
      e1 = exp_v(psrc1);
      e2 = exp_v(psrc2);
      checks++;
      if (v1 !== e1) begin
        errors++; $display("FAIL random_v1: cycle %0d got %b expected %b", c, v1, e1);
      end
      checks++;
      if (v2 !== e2) begin
        errors++; $display("FAIL random_v2: cycle %0d got %b expected %b", c, v2, e2);
      end
      tick();
`ifdef PRT_PERF_EN
      checks++;
      if (busy_cnt !== 7'(m_busy)) begin
        errors++; $display("FAIL random_busy_cnt: cycle %0d got %0d expected %0d", c, busy_cnt, m_busy);
      end
      checks++;
      if (alloc_conflict !== m_conf) begin
        errors++; $display("FAIL random_conflict: cycle %0d got %b expected %b", c, alloc_conflict, m_conf);
      end
`endif
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    int n;
    clear_inputs();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) begin
        n = 1 + 4*c + i;
        alloc_valid[i] = (n <= 30);
        alloc_preg[i*W +: W] = 6'(n);
      end
      tick();
    end
    clear_inputs();
    psrc1 = pack4(1, 2, 3, 4);
    psrc2 = pack4(27, 28, 29, 30);
    #2;
    checks++;
    if ({v1, v2} !== 8'h00) begin
      errors++; $display("FAIL busy_before_reset: v1 %b v2 %b expected 0000 0000", v1, v2);
    end
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({v1, v2} !== 8'hFF) begin
      errors++; $display("FAIL async_reset: v1 %b v2 %b expected 1111 1111", v1, v2);
    end
`ifdef PRT_PERF_EN
    checks++;
    if (busy_cnt !== 7'd0) begin
      errors++; $display("FAIL async_reset_busy_cnt: got %0d expected 0", busy_cnt);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_alloc_wake_bypass();
    test_intra_group();
    test_alloc_wake_conflict();
    test_flush();
    test_preg0();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
